// File: rtl/dsp_mac_slice.sv
// dsp_mac_slice: three-stage signed pre-add / multiply / post-add MAC engine
// with a valid/ready stream handshake, NCH channel-interleaved accumulators
// and optional post-adder saturation.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   in_valid / in_ready input beat handshake (in_ready = whole-pipe advance)
//   a, b, d, c, pcin    operands (signed); pcin is the cascade input
//   carryin             post-adder carry/borrow input
//   opmode              [0] PRE_EN [1] PRE_SUB [3:2] ZSEL [4] POST_SUB [5] ACC_WR
//   ch                  accumulator channel of the beat
//   acc_clr             synchronous clear of all accumulators
//   out_valid/out_ready result beat handshake
//   p, pcout            result (pcout mirrors p for cascading)
//   m                   multiplier result of the output beat
//   ch_out              channel tag of the output beat
//   carryout, ovf       raw post-adder carry, signed overflow of the beat
module dsp_mac_slice #(
    parameter int A_W    = 18,
    parameter int B_W    = 18,
    parameter int C_W    = 48,
    parameter int P_W    = 48,
    parameter int NCH    = 4,
    parameter int SAT_EN = 0,
    localparam int CH_W  = (NCH > 1) ? $clog2(NCH) : 1,
    localparam int M_W   = A_W + B_W + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [A_W-1:0]    a,
    input  logic [B_W-1:0]    b,
    input  logic [B_W-1:0]    d,
    input  logic [C_W-1:0]    c,
    input  logic [P_W-1:0]    pcin,
    input  logic              carryin,
    input  logic [5:0]        opmode,
    input  logic [CH_W-1:0]   ch,
    input  logic              acc_clr,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [P_W-1:0]    p,
    output logic [P_W-1:0]    pcout,
    output logic [M_W-1:0]    m,
    output logic [CH_W-1:0]   ch_out,
    output logic              carryout,
    output logic              ovf
);

    logic                     ce_s;

    logic signed [A_W-1:0]    a_s1_r;
    logic signed [B_W-1:0]    b_s1_r;
    logic signed [B_W-1:0]    d_s1_r;
    logic signed [C_W-1:0]    c_s1_r;
    logic [P_W-1:0]           pcin_s1_r;
    logic                     cin_s1_r;
    logic [5:0]               op_s1_r;
    logic [CH_W-1:0]          ch_s1_r;
    logic                     v_s1_r;

    logic signed [B_W:0]      pre_s;
    logic signed [M_W-1:0]    m_s;

    logic signed [M_W-1:0]    m_s2_r;
    logic signed [C_W-1:0]    c_s2_r;
    logic [P_W-1:0]           pcin_s2_r;
    logic                     cin_s2_r;
    logic [5:2]               op_s2_r;
    logic [CH_W-1:0]          ch_s2_r;
    logic                     v_s2_r;

    logic [P_W-1:0]           acc_r [NCH];

    logic                     ch_ok_s;
    logic [P_W-1:0]           z_s;
    logic [P_W-1:0]           mx_s;
    logic [P_W:0]             r_s;
    logic signed [P_W+1:0]    ez_s;
    logic signed [P_W+1:0]    em_s;
    logic signed [P_W+1:0]    ec_s;
    logic signed [P_W+1:0]    ex_s;
    logic                     ovf_s;
    logic [P_W-1:0]           p_next_s;

    logic [P_W-1:0]           p_r;
    logic [M_W-1:0]           m_r;
    logic [CH_W-1:0]          ch_out_r;
    logic                     carryout_r;
    logic                     ovf_r;
    logic                     out_valid_r;

    // Whole-pipe advance: move when the output slot is empty or being taken.
    assign ce_s     = !out_valid_r || out_ready;
    assign in_ready = ce_s;

    // Stage 1: capture the input beat and its control.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_s1_r    <= {A_W{1'b0}};
            b_s1_r    <= {B_W{1'b0}};
            d_s1_r    <= {B_W{1'b0}};
            c_s1_r    <= {C_W{1'b0}};
            pcin_s1_r <= {P_W{1'b0}};
            cin_s1_r  <= 1'b0;
            op_s1_r   <= 6'b000000;
            ch_s1_r   <= {CH_W{1'b0}};
            v_s1_r    <= 1'b0;
        end else if (ce_s) begin
            a_s1_r    <= a;
            b_s1_r    <= b;
            d_s1_r    <= d;
            c_s1_r    <= c;
            pcin_s1_r <= pcin;
            cin_s1_r  <= carryin;
            op_s1_r   <= opmode;
            ch_s1_r   <= ch;
            v_s1_r    <= in_valid;
        end
    end

    // Pre-adder at B_W+1 bits (no truncation) feeding the signed multiplier.
    always_comb begin
        pre_s = (B_W+1)'(b_s1_r);
        if (op_s1_r[0]) begin
            if (op_s1_r[1]) begin
                pre_s = (B_W+1)'(d_s1_r) - (B_W+1)'(b_s1_r);
            end else begin
                pre_s = (B_W+1)'(d_s1_r) + (B_W+1)'(b_s1_r);
            end
        end else begin
            pre_s = (B_W+1)'(b_s1_r);
        end
        m_s = M_W'(a_s1_r) * M_W'(pre_s);
    end

    // Stage 2: register the product and carry post-adder operands forward.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_s2_r    <= {M_W{1'b0}};
            c_s2_r    <= {C_W{1'b0}};
            pcin_s2_r <= {P_W{1'b0}};
            cin_s2_r  <= 1'b0;
            op_s2_r   <= 4'b0000;
            ch_s2_r   <= {CH_W{1'b0}};
            v_s2_r    <= 1'b0;
        end else if (ce_s) begin
            m_s2_r    <= m_s;
            c_s2_r    <= c_s1_r;
            pcin_s2_r <= pcin_s1_r;
            cin_s2_r  <= cin_s1_r;
            op_s2_r   <= op_s1_r[5:2];
            ch_s2_r   <= ch_s1_r;
            v_s2_r    <= v_s1_r;
        end
    end

    // Post-adder: Z select, raw P_W+1 bit carry path, exact signed overflow
    // check and optional saturation toward the sign of Z.
    always_comb begin
        ch_ok_s = ({{(32-CH_W){1'b0}}, ch_s2_r} < NCH);
        mx_s    = P_W'(m_s2_r);
        case (op_s2_r[3:2])
            2'd0:    z_s = {P_W{1'b0}};
            2'd1:    z_s = P_W'(c_s2_r);
            2'd2:    z_s = ch_ok_s ? acc_r[ch_s2_r] : {P_W{1'b0}};
            2'd3:    z_s = pcin_s2_r;
            default: z_s = {P_W{1'b0}};
        endcase
        ez_s = (P_W+2)'($signed(z_s));
        em_s = (P_W+2)'($signed(mx_s));
        ec_s = {{(P_W+1){1'b0}}, cin_s2_r};
        if (op_s2_r[4]) begin
            r_s  = {1'b0, z_s} - ({1'b0, mx_s} + {{P_W{1'b0}}, cin_s2_r});
            ex_s = ez_s - em_s - ec_s;
        end else begin
            r_s  = {1'b0, z_s} + {1'b0, mx_s} + {{P_W{1'b0}}, cin_s2_r};
            ex_s = ez_s + em_s + ec_s;
        end
        // Overflow when the exact result is not the sign extension of its low P_W bits.
        ovf_s = (ex_s != (P_W+2)'($signed(ex_s[P_W-1:0])));
        if ((SAT_EN != 32'sd0) && ovf_s) begin
            p_next_s = z_s[P_W-1] ? {1'b1, {(P_W-1){1'b0}}} : {1'b0, {(P_W-1){1'b1}}};
        end else begin
            p_next_s = r_s[P_W-1:0];
        end
    end

    // Stage 3: output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p_r         <= {P_W{1'b0}};
            m_r         <= {M_W{1'b0}};
            ch_out_r    <= {CH_W{1'b0}};
            carryout_r  <= 1'b0;
            ovf_r       <= 1'b0;
            out_valid_r <= 1'b0;
        end else if (ce_s) begin
            p_r         <= p_next_s;
            m_r         <= m_s2_r;
            ch_out_r    <= ch_s2_r;
            carryout_r  <= r_s[P_W];
            ovf_r       <= ovf_s;
            out_valid_r <= v_s2_r;
        end
    end

    // Accumulators: written by valid ACC_WR beats leaving stage 2; acc_clr
    // wins and acts even while the pipe is stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NCH; i++) acc_r[i] <= {P_W{1'b0}};
        end else if (acc_clr) begin
            for (int i = 0; i < NCH; i++) acc_r[i] <= {P_W{1'b0}};
        end else if (ce_s && v_s2_r && op_s2_r[5] && ch_ok_s) begin
            acc_r[ch_s2_r] <= p_next_s;
        end
    end

    assign p         = p_r;
    assign pcout     = p_r;
    assign m         = m_r;
    assign ch_out    = ch_out_r;
    assign carryout  = carryout_r;
    assign ovf       = ovf_r;
    assign out_valid = out_valid_r;

endmodule

// File: doc/dsp_mac_slice.md
Name: dsp_mac_slice

Overview:
- Parametrised successor to the fixed 18x18 DSP slice: a signed pre-add / multiply / post-add pipeline whose operand widths and accumulator channel count are generics.
- Adds a valid/ready stream handshake with whole-pipe stall, NCH channel-interleaved accumulators, and optional saturation with an overflow flag.
- Sits in the datapath as a drop-in MAC engine for filters and cascaded (PCIN/PCOUT) arithmetic chains.

Parameters:
- A_W, 18, signed width of a.
- B_W, 18, signed width of b and d. Pre-adder result is B_W+1 bits, no truncation.
- C_W, 48, signed width of c. Sign-extended to P_W.
- P_W, 48, width of p, pcout and pcin. Must be >= A_W+B_W+1.
- NCH, 4, number of accumulator channels. Localparam CH_W = max(1, clog2(NCH)).
- SAT_EN, 0, 1 = saturate the post-adder to signed P_W limits; 0 = wrap.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  input beat valid.
- in_ready  out  1  pipeline can accept a beat.
- a  in  A_W  multiplier operand (signed).
- b  in  B_W  pre-adder operand / multiplier operand (signed).
- d  in  B_W  pre-adder operand (signed).
- c  in  C_W  post-adder operand (signed).
- pcin  in  P_W  cascade input.
- carryin  in  1  post-adder carry/borrow input.
- opmode  in  6  [0] PRE_EN, [1] PRE_SUB, [3:2] ZSEL (0 = zero, 1 = c, 2 = acc[ch], 3 = pcin), [4] POST_SUB, [5] ACC_WR.
- ch  in  CH_W  accumulator channel of this beat. Values >= NCH are illegal.
- acc_clr  in  1  synchronous clear of all accumulators.
- out_valid  out  1  result beat valid.
- out_ready  in  1  downstream accepts the result.
- p  out  P_W  result.
- pcout  out  P_W  equals p; cascade output.
- m  out  A_W+B_W+1  multiplier result of the current output beat.
- ch_out  out  CH_W  channel tag of the output beat.
- carryout  out  1  raw post-adder carry.
- ovf  out  1  signed overflow of this output beat.

Behaviour:
- Reset (rst_n = 0, any time, including mid-stream): all stage registers, valids, p, m, ch_out, carryout, ovf and every acc[i] go to 0 immediately. In-flight beats are discarded. in_ready = 1 after reset.
- Advance enable: ce = !out_valid | out_ready. in_ready = ce (combinational). When ce = 0, every stage holds its contents and no accumulator is written.
- Stage 1 (on ce): register a, b, d, c, pcin, carryin, opmode, ch, and in_valid. A beat is accepted when in_valid & in_ready.
- Stage 2 (on ce):
  - pre = PRE_EN ? (PRE_SUB ? d-b : d+b) : b, computed at B_W+1 bits, signed.
  - m_s2 = a * pre, signed, A_W+B_W+1 bits. Registered.
- Stage 3 (on ce):
  - Z is selected by ZSEL. Mx = m_s2 sign-extended to P_W.
  - Add: r = Z + Mx + cin. Sub (POST_SUB = 1): r = Z - (Mx + cin).
  - Computed at P_W+1 bits unsigned. carryout = r[P_W].
  - ovf = signed overflow of the P_W-bit result.
  - p = SAT_EN & ovf ? (sign of Z ? min signed : max signed) : r[P_W-1:0].
  - out_valid, ch_out and m follow stage 3.
- Latency: an accepted beat appears 3 ce-cycles later. Throughput is 1 beat per cycle while unstalled. Bubbles are not collapsed.
- Accumulators:
  - acc[ch] is written with the (saturated) p when a valid stage-3 beat with ACC_WR = 1 advances.
  - ZSEL = 2 reads acc[ch] at stage 3, so back-to-back beats on the same channel accumulate correctly with no hazard stall.
  - acc_clr clears all channels at the next edge regardless of ce, and wins over a simultaneous write.
- Invalid beats still move through the pipe but never write accumulators and never assert out_valid.

Test Plan:
- Reset mid-stream: drive beats, pull rst_n low between edges -> out_valid = 0, p = m = 0, carryout = ovf = 0 immediately; after release, in_ready = 1 and acc reads 0.
- Pre-add MAC: opmode = 000101 (PRE_EN, ZSEL = c), a = 20, b = 10, d = 25, c = 350, carryin = 0 -> 3 cycles later out_valid = 1, m = 700 (0x2BC), p = 1050.
- Interleaved accumulate: opmode = 101000 (ZSEL = acc, ACC_WR), beats alternate ch0 (a = 2, b = 3) and ch1 (a = 4, b = 5), 4 beats each -> ch0 p = 6, 12, 18, 24; ch1 p = 20, 40, 60, 80. A following acc_clr makes the next ch0 beat give 6.
- Overflow: c = 0x7FFF_FFFF_FFFF, a = b = 1, ZSEL = c -> SAT_EN = 1: p = 0x7FFF_FFFF_FFFF, ovf = 1; SAT_EN = 0: p = 0x8000_0000_0000, ovf = 1.
- Cascade subtract: opmode = 011100 (ZSEL = pcin, POST_SUB), pcin = 3000, a = 5, b = 6, carryin = 1 -> m = 30, p = pcout = 2969, carryout = 0.
- Backpressure: hold out_ready = 0 with out_valid = 1 for 5 cycles -> in_ready = 0, p and ch_out stable, no accumulator change. On release, every accepted beat is output exactly once, in order.
